uart_tx: RTL and testbench

Byte-wide UART transmitter with a small input FIFO: it accepts parallel bytes over a valid/ready handshake and serialises them as 8N1 frames (optionally 8E1). It drives the serial line that `uart_rx` samples, and forms the transmit half of the UART link. Byte delivery is lossless: a byte is accepted only when the FIFO has room.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_tx.sv | 142 ++++++++++++++
 tb/tb_uart_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame constants and bit-timing helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                               input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter: registered read/write pointers plus an occupancy count.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialised as 8N1 frames, or 8E1 when
// UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       data_out,
  output logic       busy
);

  localparam int unsigned CPB    = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam logic [31:0] CPB_M1 = 32'(CPB - 1);
  localparam logic [2:0]  IDX_LAST = 3'(DATA_BITS - 1);

  uart_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        data_out_q, data_out_d;
  logic        bit_end, load;

  logic        push, full, empty;
  logic [7:0]  rdata;
  logic [$clog2(FIFO_DEPTH):0] count;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif

  assign tx_ready = !full;
  assign push     = tx_valid && tx_ready;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (load),
    .wdata_i (tx_data),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign bit_end = (cnt_q == CPB_M1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + 32'd1;
    idx_d      = idx_q;
    shift_d    = shift_q;
    data_out_d = 1'b1;
    load       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        data_out_d = 1'b0;
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        data_out_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (idx_q == IDX_LAST) state_d = ST_PARITY;
`else
          if (idx_q == IDX_LAST) state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        data_out_d = par_q;
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more bytes are queued.
          if (!empty) begin
            load    = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      shift_d = rdata;
`ifdef UART_TX_PARITY_EN
      par_d   = ^rdata;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_out_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // Registered line output: the start bit appears two edges after acceptance.
  assign data_out = data_out_q;
  assign busy     = (state_q != ST_IDLE) || (count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=10 with a mid-bit line monitor.
module tb_uart_tx;
  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = CPB * NBITS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, data_out, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.BAUD_RATE(100000), .CLOCK_FREQ(1000000), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .data_out (data_out),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line monitor: frames start on a falling edge, bits sampled 5 cycles into each bit.
  logic [7:0] rx_q[$];
  int         rx_start[$];
  logic       rx_par[$];
  logic       mon_act = 1'b0, mon_prev = 1'b1, mon_p = 1'b0;
  logic [7:0] mon_sh = 8'h00;
  int         mon_s = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_act  = 1'b0;
      mon_prev = 1'b1;
    end else begin
      if (!mon_act) begin
        if (mon_prev && !data_out) begin
          mon_act = 1'b1;
          mon_s   = cyc;
        end
      end else if ((cyc - mon_s) % CPB == 5) begin
        int b;
        b = (cyc - mon_s) / CPB;
        if (b == 0) chk("start_bit", 32'(data_out), 0);
        else if (b <= 8) mon_sh[b-1] = data_out;
        else if (b == NBITS - 1) begin
          chk("stop_bit", 32'(data_out), 1);
          rx_q.push_back(mon_sh);
          rx_start.push_back(mon_s);
          rx_par.push_back(mon_p);
          mon_act = 1'b0;
        end else mon_p = data_out;
      end
      mon_prev = data_out;
    end
  end

  function automatic logic [31:0] qb(input int i);
    if (i < rx_q.size()) return 32'(rx_q[i]);
    return 32'hDEAD;
  endfunction

  function automatic logic [31:0] qs(input int i);
    if (i < rx_start.size()) return 32'(rx_start[i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic clear_mon();
    rx_q.delete();
    rx_start.delete();
    rx_par.delete();
  endtask

  // Called at a negedge; leaves tx_valid high, returns at the negedge after acceptance.
  task automatic push(input logic [7:0] b, output int acc);
    int n = 0;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) chk("push_timeout", 0, 1);
    tx_valid = 1'b1;
    tx_data  = b;
    acc      = cyc + 1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int n, input int budget);
    int k = 0;
    while ((rx_q.size() < n || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (2 * CPB) @(negedge clk);
    chk("frame_count", 32'(rx_q.size()), 32'(n));
    chk("busy_after", 32'(busy), 0);
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc0, tmp, lowcnt, bcnt;
    logic [7:0] fifo_bytes [5];
    fifo_bytes[0] = 8'h00; fifo_bytes[1] = 8'hFF; fifo_bytes[2] = 8'h3C;
    fifo_bytes[3] = 8'h81; fifo_bytes[4] = 8'h5A;

    // Reset state and quiet line
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 1);
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    lowcnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (!data_out || busy) lowcnt++;
    end
    chk("idle_100", 32'(lowcnt), 0);
    chk("idle_no_frame", 32'(rx_q.size()), 0);

    // Single byte 0xA5: latency, bit pattern, busy window
    clear_mon();
    push(8'hA5, acc);
    tx_valid = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 150; i++) begin
      if (busy) bcnt++;
      @(negedge clk);
    end
    chk("a5_byte", qb(0), 32'hA5);
    chk("a5_latency", qs(0) - 32'(acc), 2);
    chk("a5_busy_cycles", 32'(bcnt), 101);
    wait_idle(1, 50);

    // Fill the FIFO, check backpressure and ignored data while full
    clear_mon();
    push(fifo_bytes[0], acc0);
    for (int i = 1; i < 5; i++) push(fifo_bytes[i], tmp);
    chk("full_ready_low", 32'(tx_ready), 0);
    tx_data = 8'hEE;
    repeat (5) @(negedge clk);
    tx_data = 8'h11;
    repeat (5) @(negedge clk);
    chk("full_ready_held", 32'(tx_ready), 0);
    tx_valid = 1'b0;
    wait_idle(5, 5 * FRAME + 100);
    for (int i = 0; i < 5; i++) chk($sformatf("fifo_byte%0d", i), qb(i), 32'(fifo_bytes[i]));
    chk("fifo_latency", qs(0) - 32'(acc0), 2);
    for (int i = 1; i < 5; i++) chk($sformatf("fifo_gap%0d", i), qs(i) - qs(i-1), 32'(FRAME));
    chk("fifo_span4", qs(4) - qs(0), 32'(4 * FRAME));

    // Continuous valid with incrementing bytes
    clear_mon();
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i), tmp);
    tx_valid = 1'b0;
    wait_idle(16, 16 * FRAME + 200);
    for (int i = 0; i < 16; i++) chk($sformatf("stream%0d", i), qb(i), 32'(8'h30 + i));

    // Reset during the data bits of 0x55, with 0x99 still queued
    clear_mon();
    push(8'h55, acc);
    push(8'h99, tmp);
    tx_valid = 1'b0;
    while (cyc < acc + 25) @(negedge clk);
    chk("pre_rst_line", 32'(data_out), 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_line", 32'(data_out), 1);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_ready", 32'(tx_ready), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    lowcnt = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (!data_out || busy) lowcnt++;
    end
    chk("post_rst_quiet", 32'(lowcnt), 0);
    chk("post_rst_no_frame", 32'(rx_q.size()), 0);
    push(8'h12, acc);
    tx_valid = 1'b0;
    wait_idle(1, FRAME + 50);
    chk("post_rst_byte", qb(0), 32'h12);
    chk("post_rst_latency", qs(0) - 32'(acc), 2);

`ifdef UART_TX_PARITY_EN
    // Even parity bit and 11-bit frame length
    clear_mon();
    push(8'h07, acc);
    push(8'h03, tmp);
    tx_valid = 1'b0;
    wait_idle(2, 2 * FRAME + 100);
    chk("par_byte0", qb(0), 32'h07);
    chk("par_byte1", qb(1), 32'h03);
    chk("par_bit_07", (rx_par.size() > 0) ? 32'(rx_par[0]) : 32'hDEAD, 1);
    chk("par_bit_03", (rx_par.size() > 1) ? 32'(rx_par[1]) : 32'hDEAD, 0);
    chk("par_frame_len", qs(1) - qs(0), 110);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
